// File: rtl/nor_seq_eval.sv
// Sequential NOR-netlist evaluator: runs a stored NOR/NOT/INIT/HALT program,
// one instruction per cycle, over a bit-cell array whose low cells hold the inputs.
module nor_seq_eval #(
  parameter int NUM_IN     = 7,
  parameter int NUM_CELLS  = 32,
  parameter int PROG_DEPTH = 32,
  parameter int IDX_W      = $clog2(NUM_CELLS),
  parameter int PC_W       = $clog2(PROG_DEPTH),
  parameter int INSTR_W    = 2 + 3*IDX_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               prog_we,
  input  logic [PC_W-1:0]    prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic [NUM_IN-1:0]  x,
  output logic               busy,
  output logic               done,
  output logic               z,
  output logic               err,
  output logic [PC_W:0]      gate_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  localparam logic [1:0]      OP_NOR  = 2'b00;
  localparam logic [1:0]      OP_NOT  = 2'b01;
  localparam logic [1:0]      OP_HALT = 2'b11;
  localparam logic [IDX_W:0]  N_IN    = (IDX_W+1)'(NUM_IN);
  localparam logic [IDX_W:0]  N_CELL  = (IDX_W+1)'(NUM_CELLS);
  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_DEPTH-1);

  logic [INSTR_W-1:0]   imem [PROG_DEPTH];
  logic [NUM_CELLS-1:0] cells;
  state_t               state;
  logic [PC_W-1:0]      pc;

  logic [INSTR_W-1:0] instr;
  logic [1:0]         op;
  logic [IDX_W-1:0]   a, b, d;
  logic               a_val, b_val, wr_val, d_bad;

  assign instr = imem[pc];
  assign op    = instr[INSTR_W-1 -: 2];
  assign a     = instr[3*IDX_W-1 -: IDX_W];
  assign b     = instr[2*IDX_W-1 -: IDX_W];
  assign d     = instr[IDX_W-1:0];

  // Indices past the array read as 0; inputs are read-only destinations.
  assign a_val = ({1'b0, a} < N_CELL) ? cells[a] : 1'b0;
  assign b_val = ({1'b0, b} < N_CELL) ? cells[b] : 1'b0;
  assign d_bad = ({1'b0, d} < N_IN) || ({1'b0, d} >= N_CELL);

  always_comb begin
    wr_val = 1'b1;
    case (op)
      OP_NOR:  wr_val = ~(a_val | b_val);
      OP_NOT:  wr_val = ~a_val;
      default: wr_val = 1'b1;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

  // Program memory has no reset; it is only writable while idle.
  always_ff @(posedge clk) begin
    if (!rst && prog_we && state == IDLE)
      imem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      pc         <= '0;
      cells      <= '0;
      z          <= 1'b0;
      err        <= 1'b0;
      gate_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cells             <= '0;
          cells[NUM_IN-1:0] <= x;
          pc                <= '0;
          gate_count        <= '0;
          err               <= 1'b0;
          state             <= LOAD;
        end
        LOAD: state <= RUN;
        RUN: begin
          if (op == OP_HALT) begin
            z     <= a_val;
            state <= FIN;
          end else if (d_bad) begin
            err   <= 1'b1;
            state <= FIN;
          end else begin
            cells[d]   <= wr_val;
            gate_count <= gate_count + 1'b1;
            if (pc == PC_LAST) begin
              err   <= 1'b1;
              state <= FIN;
            end else begin
              pc <= pc + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_seq_eval.sv
// Scoreboard bench for nor_seq_eval: stimulus pushes expected completions,
// a negedge monitor pops and checks them whenever done is seen.
module tb_nor_seq_eval;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        prog_we = 1'b0;
  logic [4:0]  prog_addr = '0;
  logic [16:0] prog_data = '0;
  logic        start = 1'b0;
  logic [6:0]  x = '0;
  logic        busy, done, z, err;
  logic [5:0]  gate_count;

  nor_seq_eval dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .start(start), .x(x), .busy(busy), .done(done),
    .z(z), .err(err), .gate_count(gate_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       z;
    logic       err;
    logic [5:0] gc;
    int         cyc;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ecnt = 0;

  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_z"}, int'(z), int'(e.z));
        chk({e.name, "_err"}, int'(err), int'(e.err));
        chk({e.name, "_gc"}, int'(gate_count), int'(e.gc));
        chk({e.name, "_cycle"}, ecnt + 1, e.cyc);
      end
    end
  end

  function automatic logic [16:0] enc(input logic [1:0] op, input int a, input int b, input int d);
    logic [4:0] a5, b5, d5;
    a5 = a[4:0]; b5 = b[4:0]; d5 = d[4:0];
    return {op, a5, b5, d5};
  endfunction

  task automatic pw(input int addr, input logic [16:0] data);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = addr[4:0]; prog_data = data;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // Start a run; expected done cycle is the accept edge count plus latency.
  task automatic issue(input string name, input logic [6:0] xv, input int lat,
                       input logic ez, input logic ee, input int egc);
    exp_t e;
    @(negedge clk);
    x = xv; start = 1'b1;
    e.z = ez; e.err = ee; e.gc = egc[5:0]; e.cyc = ecnt + 1 + lat; e.name = name;
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk({name, "_timeout"}, 1, 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    exp_t e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_z", int'(z), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_gc", int'(gate_count), 0);

    // OR(x0,x1) = NOT(NOR(x0,x1))
    pw(0, enc(2'b00, 0, 1, 7));
    pw(1, enc(2'b01, 7, 0, 8));
    pw(2, enc(2'b11, 8, 0, 0));
    issue("or_x2", 7'b0000010, 5, 1'b1, 1'b0, 2);
    wait_done("or_x2");
    issue("or_x0", 7'b0000000, 5, 1'b0, 1'b0, 2);
    wait_done("or_x0");

    // INIT then read-after-write chain: 1 -> 0 -> 1
    pw(0, enc(2'b10, 0, 0, 9));
    pw(1, enc(2'b00, 9, 9, 10));
    pw(2, enc(2'b01, 10, 0, 11));
    pw(3, enc(2'b11, 11, 0, 0));
    issue("raw", 7'b0000000, 6, 1'b1, 1'b0, 3);
    wait_done("raw");

    // Writing an input cell aborts; z held at 1 from the previous run
    pw(0, enc(2'b00, 0, 1, 3));
    issue("prot", 7'b0001000, 3, 1'b1, 1'b1, 0);
    wait_done("prot");
    chk("prot_cell3", int'(dut.cells[3]), 1);

    // Overrun: no HALT anywhere
    for (int i = 0; i < 32; i++) pw(i, enc(2'b01, 0, 0, 7));
    issue("overrun", 7'b0000001, 34, 1'b1, 1'b1, 32);
    wait_done("overrun");

    // Handshake: start/prog_we during RUN are ignored. x0=1 -> c7=0,c8=1,c9=0
    pw(0, enc(2'b01, 0, 0, 7));
    pw(1, enc(2'b01, 7, 0, 8));
    pw(2, enc(2'b01, 8, 0, 9));
    pw(3, enc(2'b11, 9, 0, 0));
    issue("busy_ign", 7'b0000001, 6, 1'b0, 1'b0, 3);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = enc(2'b11, 8, 0, 0); start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done("busy_ign");
    issue("reread", 7'b0000001, 6, 1'b0, 1'b0, 3);
    wait_done("reread");

    // Same-cycle write+start in IDLE: new HALT(a=8) is used
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 5'd3; prog_data = enc(2'b11, 8, 0, 0);
    x = 7'b0000001; start = 1'b1;
    e.z = 1'b1; e.err = 1'b0; e.gc = 6'd3; e.cyc = ecnt + 1 + 6; e.name = "same_cyc";
    q.push_back(e);
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    wait_done("same_cyc");

    // Reset mid-run of a 10-instruction program: INIT c7, NOT chain to c15, HALT
    pw(0, enc(2'b10, 0, 0, 7));
    for (int i = 1; i < 9; i++) pw(i, enc(2'b01, 6 + i, 0, 7 + i));
    pw(9, enc(2'b11, 15, 0, 0));
    issue("pre_rst", 7'b0000000, 12, 1'b1, 1'b0, 9);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_z", int'(z), 0);
    chk("midrst_err", int'(err), 0);
    chk("midrst_gc", int'(gate_count), 0);
    repeat (15) @(negedge clk);
    issue("post_rst", 7'b0000000, 12, 1'b1, 1'b0, 9);
    wait_done("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
